// File: rtl/ahb_bram_ctrl.sv
// Zero-wait-state AHB-Lite slave bridging to a simple dual-port BRAM with one-cycle reads.
// Writes land one cycle after the address phase; an immediately following same-word read is bypassed.
module ahb_bram_ctrl #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [3:0]            HPROT,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDRA,
    output logic [3:0]            BRAM_WEA,
    output logic [31:0]           BRAM_DINA,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDRB,
    input  logic [31:0]           BRAM_DOUTB
);

    logic                  acc;
    logic [ADDR_WIDTH-1:0] word;
    logic [3:0]            strb;
    logic                  fwd_next;

    logic                  wr_pend;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [3:0]            wr_strb;
    logic                  fwd_hit;
    logic [3:0]            fwd_strb;
    logic [31:0]           fwd_data;

    logic unused_ok;
    assign unused_ok = ^{HPROT, HADDR[31:ADDR_WIDTH+2]};

    assign acc  = HSEL & HTRANS[1] & HREADY;
    assign word = HADDR[ADDR_WIDTH+1:2];

    // Misaligned low address bits simply select lanes; no error response is generated.
    always_comb begin
        strb = 4'b0000;
        if (HSIZE == 3'd0)
            strb = 4'b0001 << HADDR[1:0];
        else if (HSIZE == 3'd1)
            strb = HADDR[1] ? 4'b1100 : 4'b0011;
        else
            strb = 4'b1111;
    end

    // BRAM returns old data on a same-edge collision, so capture the write being committed now.
    assign fwd_next = acc & ~HWRITE & wr_pend & (word == wr_addr);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wr_pend  <= 1'b0;
            wr_addr  <= '0;
            wr_strb  <= 4'b0000;
            fwd_hit  <= 1'b0;
            fwd_strb <= 4'b0000;
            fwd_data <= 32'h0;
        end else begin
            wr_pend <= acc & HWRITE;
            if (acc & HWRITE) begin
                wr_addr <= word;
                wr_strb <= strb;
            end
            fwd_hit <= fwd_next;
            if (fwd_next) begin
                fwd_strb <= wr_strb;
                fwd_data <= HWDATA;
            end
        end
    end

    assign BRAM_WEA   = wr_pend ? wr_strb : 4'b0000;
    assign BRAM_ADDRA = wr_addr;
    assign BRAM_DINA  = HWDATA;
    assign BRAM_ADDRB = word;

    always_comb begin
        HRDATA = BRAM_DOUTB;
        for (int i = 0; i < 4; i++) begin
            if (fwd_hit && fwd_strb[i])
                HRDATA[8*i +: 8] = fwd_data[8*i +: 8];
        end
    end

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Scoreboarded bench for ahb_bram_ctrl with a behavioural read-old-data BRAM attached.
module tb_ahb_bram_ctrl;
    localparam int ADDR_WIDTH = 14;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    logic                  HCLK = 1'b0;
    logic                  HRESET;
    logic                  HSEL;
    logic [31:0]           HADDR;
    logic [1:0]            HTRANS;
    logic [2:0]            HSIZE;
    logic [3:0]            HPROT;
    logic                  HWRITE;
    logic [31:0]           HWDATA;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic                  HRESP;
    logic [31:0]           HRDATA;
    logic [ADDR_WIDTH-1:0] BRAM_ADDRA;
    logic [3:0]            BRAM_WEA;
    logic [31:0]           BRAM_DINA;
    logic [ADDR_WIDTH-1:0] BRAM_ADDRB;
    logic [31:0]           BRAM_DOUTB;

    ahb_bram_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .BRAM_ADDRA(BRAM_ADDRA), .BRAM_WEA(BRAM_WEA), .BRAM_DINA(BRAM_DINA),
        .BRAM_ADDRB(BRAM_ADDRB), .BRAM_DOUTB(BRAM_DOUTB)
    );

    always #5 HCLK = ~HCLK;

    function automatic logic [31:0] init_word(input int i);
        return 32'(i) * 32'h9E3779B9 + 32'h1234_5678;
    endfunction

    // Block RAM model: byte-enabled port A, registered port B, old data on collision.
    logic [31:0] bram [0:DEPTH-1];
    logic        bram_init_done = 1'b0;
    always @(posedge HCLK) begin
        if (!bram_init_done) begin
            for (int i = 0; i < DEPTH; i++) bram[i] <= init_word(i);
            bram_init_done <= 1'b1;
            BRAM_DOUTB     <= init_word(int'(BRAM_ADDRB));
        end else begin
            for (int i = 0; i < 4; i++)
                if (BRAM_WEA[i]) bram[BRAM_ADDRA][8*i +: 8] <= BRAM_DINA[8*i +: 8];
            BRAM_DOUTB <= bram[BRAM_ADDRB];
        end
    end

    // Reference memory: the value software must observe, updated in bus order.
    logic [31:0] ref_mem [int];
    function automatic logic [31:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [3:0] exp_strb(input logic [2:0] size, input logic [1:0] lo);
        if (size == 3'd0) return 4'b0001 << lo;
        if (size == 3'd1) return lo[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    logic [31:0]           exp_q [$];
    logic                  pend_w = 1'b0;
    logic                  pend_r = 1'b0;
    logic [ADDR_WIDTH-1:0] pend_addr = '0;
    logic [3:0]            pend_strb = 4'h0;

    // One bus cycle: drive an address phase plus the data-phase HWDATA of the previous one.
    task automatic do_cycle(input logic sel, input logic [1:0] trans, input logic rdy,
                            input logic wr, input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] wdata);
        logic [3:0]            e_wea;
        logic [ADDR_WIDTH-1:0] e_addra;
        logic                  rd_due;
        logic [31:0]           w;
        int                    a;
        @(posedge HCLK); #1;
        HSEL = sel; HTRANS = trans; HREADY = rdy; HWRITE = wr;
        HADDR = addr; HSIZE = size; HWDATA = wdata;
        e_wea   = pend_w ? pend_strb : 4'h0;
        e_addra = pend_addr;
        if (pend_w) begin
            w = ref_rd(int'(pend_addr));
            for (int i = 0; i < 4; i++)
                if (pend_strb[i]) w[8*i +: 8] = wdata[8*i +: 8];
            ref_mem[int'(pend_addr)] = w;
        end
        rd_due = pend_r;
        pend_w = 1'b0;
        pend_r = 1'b0;
        if (sel && trans[1] && rdy) begin
            a = int'(addr[ADDR_WIDTH+1:2]);
            if (wr) begin
                pend_w    = 1'b1;
                pend_addr = addr[ADDR_WIDTH+1:2];
                pend_strb = exp_strb(size, addr[1:0]);
            end else begin
                pend_r = 1'b1;
                exp_q.push_back(ref_rd(a));
            end
        end
        @(negedge HCLK);
        check_eq("wea", 32'(BRAM_WEA), 32'(e_wea));
        if (e_wea != 4'h0) check_eq("addra", 32'(BRAM_ADDRA), 32'(e_addra));
        check_eq("addrb", 32'(BRAM_ADDRB), 32'(addr[ADDR_WIDTH+1:2]));
        check_eq("hreadyout", 32'(HREADYOUT), 32'd1);
        check_eq("hresp", 32'(HRESP), 32'd0);
        if (rd_due) begin
            if (exp_q.size() == 0) check_eq("scoreboard_empty", 32'd0, 32'd1);
            else check_eq("hrdata", HRDATA, exp_q.pop_front());
        end
    endtask

    task automatic wr_cyc(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
        do_cycle(1'b1, 2'b10, 1'b1, 1'b1, addr, size, wdata);
    endtask
    task automatic rd_cyc(input logic [31:0] addr, input logic [31:0] wdata);
        do_cycle(1'b1, 2'b10, 1'b1, 1'b0, addr, 3'd2, wdata);
    endtask
    task automatic idle_cyc(input logic [31:0] wdata);
        do_cycle(1'b0, 2'b00, 1'b1, 1'b0, 32'h0, 3'd2, wdata);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESET = 1'b1; HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HSIZE = 3'd2;
        HPROT = 4'h3; HWRITE = 1'b0; HWDATA = 32'h0; HREADY = 1'b1;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check_eq("rst_wea", 32'(BRAM_WEA), 32'd0);
        check_eq("rst_addra", 32'(BRAM_ADDRA), 32'd0);
        check_eq("rst_hrdata", HRDATA, bram[0]);
        check_eq("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        check_eq("rst_hresp", 32'(HRESP), 32'd0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;

        // Word write, idle, read back two cycles later.
        wr_cyc(32'h1000, 3'd2, 32'h0);
        idle_cyc(32'hDEADBEEF);
        rd_cyc(32'h1000, 32'h0);
        idle_cyc(32'h0);
        check_eq("word_wr_val", ref_rd(32'h400), 32'hDEADBEEF);

        // Byte lanes then halfword overwrite.
        wr_cyc(32'h2000, 3'd0, 32'h0);
        wr_cyc(32'h2001, 3'd0, 32'h0000_0011);
        wr_cyc(32'h2002, 3'd0, 32'h0000_2200);
        wr_cyc(32'h2003, 3'd0, 32'h0033_0000);
        wr_cyc(32'h2002, 3'd1, 32'h4400_0000);
        idle_cyc(32'hAAAA_0000);
        rd_cyc(32'h2000, 32'h0);
        idle_cyc(32'h0);
        check_eq("byte_hw_val", ref_rd(32'h800), 32'hAAAA2211);

        // Forwarding: read in the write's data phase.
        wr_cyc(32'h3000, 3'd2, 32'h0);
        rd_cyc(32'h3000, 32'h12345678);
        wr_cyc(32'h3001, 3'd0, 32'h0);
        rd_cyc(32'h3000, 32'h0000_FF00);
        idle_cyc(32'h0);
        check_eq("fwd_byte_val", ref_rd(32'hC00), 32'h1234FF78);

        // Neighbouring word must not be forwarded.
        wr_cyc(32'h4000, 3'd2, 32'h0);
        rd_cyc(32'h4004, 32'h5555AAAA);
        rd_cyc(32'h4000, 32'h0);
        idle_cyc(32'h0);

        // Rejected address phases with HWRITE=1.
        do_cycle(1'b1, 2'b00, 1'b1, 1'b1, 32'h5000, 3'd2, 32'h0);
        idle_cyc(32'hBAD0_0001);
        do_cycle(1'b1, 2'b01, 1'b1, 1'b1, 32'h5004, 3'd2, 32'h0);
        idle_cyc(32'hBAD0_0002);
        do_cycle(1'b0, 2'b10, 1'b1, 1'b1, 32'h5008, 3'd2, 32'h0);
        idle_cyc(32'hBAD0_0003);
        do_cycle(1'b1, 2'b10, 1'b0, 1'b1, 32'h500C, 3'd2, 32'h0);
        idle_cyc(32'hBAD0_0004);
        for (int i = 0; i < 4; i++) rd_cyc(32'h5000 + 32'(4 * i), 32'h0);
        idle_cyc(32'h0);

        // Reset asserted during a write data phase loses the write.
        wr_cyc(32'h6000, 3'd2, 32'h0);
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hCAFEF00D;
        check_eq("pre_rst_wea", 32'(BRAM_WEA), 32'hF);
        HRESET = 1'b1;
        #1;
        check_eq("rst_mid_wea", 32'(BRAM_WEA), 32'd0);
        pend_w = 1'b0;
        pend_r = 1'b0;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        rd_cyc(32'h6000, 32'h0);
        idle_cyc(32'h0);
        check_eq("rst_lost_bram", bram[32'h1800], init_word(32'h1800));

        check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb_bram_ctrl.md
# ahb_bram_ctrl

AHB-Lite slave controller that sits between the Cortex-M0 system bus and the simple dual-port block RAM (port A byte-enabled write, port B registered read, one-cycle read latency). It converts AHB address/data-phase transfers into BRAM write strobes and read addresses. It also forwards write data into an immediately following read of the same word, so software sees coherent memory with zero wait states.

## Interface
- ADDR_WIDTH, 14, BRAM word-address width; byte span is 2^(ADDR_WIDTH+2)

- HCLK  in  1  system clock; also clocks the BRAM
- HRESET  in  1  asynchronous, active-high reset
- HSEL  in  1  slave select
- HADDR  in  32  byte address; word index = HADDR[ADDR_WIDTH+1:2]
- HTRANS  in  2  transfer type; only NONSEQ/SEQ (HTRANS[1]=1) are acted on
- HSIZE  in  3  transfer size
- HPROT  in  4  ignored
- HWRITE  in  1  1 = write
- HWDATA  in  32  write data, valid in data phase
- HREADY  in  1  bus-wide ready; address phase sampled only when 1
- HREADYOUT  out  1  constant 1
- HRESP  out  1  constant 0 (OKAY)
- HRDATA  out  32  read data, valid in data phase
- BRAM_ADDRA  out  ADDR_WIDTH  port-A write word address
- BRAM_WEA  out  4  port-A byte write enables
- BRAM_DINA  out  32  port-A write data
- BRAM_ADDRB  out  ADDR_WIDTH  port-B read word address
- BRAM_DOUTB  in  32  port-B registered read data

## Operation
- Transfer accepted in address phase: acc = HSEL & HTRANS[1] & HREADY.
- Byte strobes from HSIZE/HADDR[1:0]:
  - HSIZE=0: one-hot lane HADDR[1:0].
  - HSIZE=1: 4'b0011 if HADDR[1]=0, else 4'b1100.
  - HSIZE>=2: 4'b1111.
  - Misaligned low bits are ignored; no error response.
- Write, acc & HWRITE:
  - Register wr_pend=1, wr_addr=word index, wr_strb=strobes.
  - Next cycle (data phase): BRAM_WEA = wr_pend ? wr_strb : 0, BRAM_ADDRA = wr_addr, BRAM_DINA = HWDATA (combinational).
  - RAM commits at the end of that cycle.
- Read:
  - BRAM_ADDRB = HADDR[ADDR_WIDTH+1:2] combinationally, every cycle.
  - On acc & ~HWRITE, BRAM_DOUTB is valid in the following cycle and drives HRDATA.
- Forwarding hazard: the BRAM is read-old-data on a same-edge collision.
  - When a read address phase coincides with a write data phase (wr_pend=1) and the word index equals wr_addr, register fwd_hit=1, fwd_strb=wr_strb, fwd_data=HWDATA.
  - Otherwise fwd_hit=0.
  - In the read data phase, per byte i: HRDATA[i] = (fwd_hit & fwd_strb[i]) ? fwd_data[i] : BRAM_DOUTB[i].
- State registers: wr_pend, wr_addr, wr_strb, fwd_hit, fwd_strb, fwd_data. wr_pend and fwd_hit each clear after one cycle unless re-set by a new accepted transfer.
- Back-to-back writes: each data-phase write coexists with the next address phase; wr_* is overwritten every accepted cycle.
- IDLE/BUSY, HSEL=0 or HREADY=0 in the address phase: no new wr_pend; any current data phase completes normally.

## Timing
- Zero wait states: HREADYOUT=1 always. Read data is presented in the cycle after the address phase.
- Write latency: RAM updated at the rising edge ending the data phase (address phase + 2 edges).
- Reset values, async assert, sync release:
  - wr_pend=0, wr_addr=0, wr_strb=0, fwd_hit=0, fwd_strb=0, fwd_data=0.
  - Hence BRAM_WEA=0, BRAM_ADDRA=0, HRDATA=BRAM_DOUTB, HREADYOUT=1, HRESP=0.
- Reset asserted during a write data phase: BRAM_WEA drops to 0 immediately and the write is lost. No partial write may occur after HRESET rises.
- Forwarding applies only to the immediately following read. A read two or more cycles after the write reads the committed RAM contents directly.
- Simultaneous same-word write data phase and read address phase: the bypass is required. Non-strobed bytes come from RAM old data.

## Test plan
- Reset: assert HRESET mid-write data phase (WEA=4'hF) -> WEA=0 same cycle; a later read of that word returns its pre-write value.
- Word write 0x1000 <- 0xDEADBEEF, IDLE, read 0x1000 -> HRDATA=0xDEADBEEF; WEA=4'hF at ADDRA=0x400 for exactly one cycle.
- Byte writes 0x11,0x22,0x33,0x44 to 0x2000..0x2003 (HSIZE=0), then halfword 0xAAAA to 0x2002, then read word -> WEA sequence 1,2,4,8,C; HRDATA=0xAAAA2211.
- Word write 0x3000 <- 0x12345678, then read 0x3000 in the very next cycle -> HRDATA=0x12345678 via forwarding. Repeat with a byte write 0xFF to 0x3001 over old 0x12345678 -> 0x1234FF78.
- Write 0x4000, immediate read 0x4004 -> no forwarding; HRDATA = 0x4004 contents.
- HTRANS=IDLE/BUSY, HSEL=0 or HREADY=0 with HWRITE=1 -> WEA stays 0, memory unchanged. HREADYOUT=1 and HRESP=0 throughout all scenarios.
